virtual_network_core_to_net: RTL and testbench
==============================================

Name: virtual_network_core_to_net

Overview:
- Transmit-side counterpart of the per-VC network-interface receiver.
- Accepts whole packets from the Cache/Directory Controller and buffers them in a packet FIFO.
- Splits each packet into flits, tags each flit with the flit type and the fixed virtual channel, and injects them into the router.
- Obeys the router's on/off back-pressure; one instance per virtual network.

Parameters:
VCID, VC0, virtual channel written into every flit header.vc_id
PACKET_BODY_SIZE, 554, packet width in bits
PACKET_FIFO_SIZE, 4, packet FIFO depth (>=4)
DEST_W, 8, destination tile ID width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  global enable; 0 freezes issue, FIFO may still accept
vn_ctn_packet_in  input  PACKET_BODY_SIZE  packet from core
vn_ctn_packet_dest  input  DEST_W  destination tile of packet
vn_ctn_packet_valid  input  1  enqueue strobe, one packet per cycle
vn_ctn_almost_full  output  1  core must stop sending packets
ni_flit_out  output  flit_t  flit to router
ni_flit_valid  output  1  ni_flit_out valid this cycle
router_credit  input  1  on/off back-pressure, 1 = stop
vn_ctn_flit_count  output  32  flits sent (see Optional Feature)

Interface rule (already decided): one clock, clk; reset is synchronous and active-high.

Behaviour:
- Derived constants:
  - FLIT_NUMB = (PACKET_BODY_SIZE+`PAYLOAD_W-1)/`PAYLOAD_W.
  - Counter width = max(1, $clog2(FLIT_NUMB)).
- Packet FIFO:
  - Stores {dest, packet}, depth PACKET_FIFO_SIZE.
  - vn_ctn_almost_full asserts when occupancy >= PACKET_FIFO_SIZE-2.
  - An enqueue while full is dropped; flagged by assertion, must never happen under the protocol.
- FSM states:
  - IDLE: if FIFO non-empty & enable & ~router_credit, go to SEND.
  - SEND: issues one flit per cycle while enable & ~router_credit.
  - When the last flit issues, dequeue the FIFO head.
  - If the FIFO is still non-empty, stay in SEND with the counter cleared; otherwise return to IDLE.
  - The first flit is issued on the same cycle as the IDLE->SEND decision.
- Flit slicing:
  - Flit k carries packet bits [k*`PAYLOAD_W +: `PAYLOAD_W], k = 0..FLIT_NUMB-1, low-order slice first.
  - The last slice is zero-padded above PACKET_BODY_SIZE.
- Flit header:
  - header.vc_id = VCID; header.destination = FIFO head dest.
  - header.flit_type: FLIT_NUMB==1 -> HT; otherwise k==0 HEAD, k==FLIT_NUMB-1 TAIL, else BODY.
- Output timing:
  - ni_flit_out and ni_flit_valid are registered: a flit issued in cycle t appears at cycle t+1.
  - ni_flit_valid is high for exactly one cycle per flit.
  - ni_flit_out holds its last value when not valid.
- Back-pressure:
  - router_credit is sampled combinationally at issue.
  - router_credit=1 in cycle t means no flit is issued in t, so no valid flit appears in t+1.
  - The packet is held mid-stream: counter and FIFO head are unchanged, and the packet resumes at the same k.
  - The router reserves a 2-flit margin.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle keep occupancy unchanged.
  - An enqueue into an empty FIFO is not issuable until the next cycle.
- enable=0: no issue; state and counter are held.
- Reset (synchronous, can occur mid-packet):
  - State IDLE, counter 0, FIFO emptied.
  - ni_flit_valid=0, ni_flit_out=0, vn_ctn_almost_full=0, vn_ctn_flit_count=0.
  - A partially sent packet is discarded; nothing further is emitted for it.

Optional Feature:
- Macro: VN_CTN_FLIT_COUNT_EN.
- Defined: vn_ctn_flit_count increments by 1 on each cycle ni_flit_valid=1, wraps at 2^32, and is cleared by reset.
- Undefined: the counter logic is absent and vn_ctn_flit_count is tied to 0.

Test Plan:
- Configuration for all scenarios: `PAYLOAD_W=64, PACKET_BODY_SIZE=200 (FLIT_NUMB=4), VCID=VC1, router_credit=0 unless stated.
- Single packet 200'h..._DDDD_CCCC_BBBB_AAAA, dest 8'h05 -> 4 consecutive valid flits, first at 1 cycle after the issue decision; types HEAD,BODY,BODY,TAIL; payloads 64-bit slices 0..3; slice 3 upper 56 bits zero; vc_id=VC1; destination 5.
- router_credit=1 for 3 cycles after the 2nd flit issues -> exactly 3-cycle gap; flits 3 and 4 resume as BODY then TAIL with correct payloads.
- PACKET_BODY_SIZE=64 instance, 3 back-to-back enqueues -> 3 HT flits on 3 consecutive cycles.
- 3 enqueues with router_credit=1 held -> vn_ctn_almost_full=1 once occupancy reaches 2; release credit -> 12 flits in order, almost_full drops to 0.
- reset asserted one cycle after the HEAD flit issues -> ni_flit_valid=0 the following cycle and stays 0; FIFO empty; a new packet then starts with HEAD.
- With VN_CTN_FLIT_COUNT_EN defined, two 4-flit packets -> vn_ctn_flit_count=8. Without the macro it stays 0.

Source files
------------

// File: rtl/virtual_network_core_to_net.sv
// virtual_network_core_to_net: per-VN packet FIFO that slices packets into flits for the router.
// Optional flit counter on vn_ctn_flit_count is built when VN_CTN_FLIT_COUNT_EN is defined.
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

package vn_ctn_pkg;
  localparam int FLIT_DEST_W = 8;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HT} flit_type_t;
  typedef enum logic [1:0] {VC0, VC1, VC2, VC3} vc_id_t;
  typedef struct packed {
    flit_type_t                flit_type;
    vc_id_t                    vc_id;
    logic [FLIT_DEST_W-1:0]    destination;
  } flit_header_t;
  typedef struct packed {
    flit_header_t              header;
    logic [`PAYLOAD_W-1:0]     payload;
  } flit_t;
endpackage

module virtual_network_core_to_net
  import vn_ctn_pkg::*;
#(
  parameter vc_id_t VCID             = VC0,
  parameter int     PACKET_BODY_SIZE = 554,
  parameter int     PACKET_FIFO_SIZE = 4,
  parameter int     DEST_W           = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PACKET_BODY_SIZE-1:0] vn_ctn_packet_in,
  input  logic [DEST_W-1:0]           vn_ctn_packet_dest,
  input  logic                        vn_ctn_packet_valid,
  output logic                        vn_ctn_almost_full,
  output flit_t                       ni_flit_out,
  output logic                        ni_flit_valid,
  input  logic                        router_credit,
  output logic [31:0]                 vn_ctn_flit_count
);
  localparam int FLIT_NUMB = (PACKET_BODY_SIZE + `PAYLOAD_W - 1) / `PAYLOAD_W;
  localparam int CNT_W     = (FLIT_NUMB > 1) ? $clog2(FLIT_NUMB) : 1;
  localparam int PAD_W     = FLIT_NUMB * `PAYLOAD_W;
  localparam int ENTRY_W   = DEST_W + PACKET_BODY_SIZE;
  localparam int PTR_W     = $clog2(PACKET_FIFO_SIZE);
  localparam int OCC_W     = $clog2(PACKET_FIFO_SIZE + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            flit_cnt, cnt_d;
  logic [ENTRY_W-1:0]          mem [PACKET_FIFO_SIZE];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [OCC_W-1:0]            fifo_cnt, occ_next;
  logic                        fifo_empty, fifo_full, enq, deq, issue, last_flit;
  logic [ENTRY_W-1:0]          head_entry;
  logic [DEST_W-1:0]           head_dest;
  logic [PACKET_BODY_SIZE-1:0] head_pkt;
  logic [PAD_W-1:0]            padded_pkt;
  flit_t                       flit_d;

  // Packet FIFO
  assign fifo_empty         = (fifo_cnt == '0);
  assign fifo_full          = (fifo_cnt == OCC_W'(PACKET_FIFO_SIZE));
  assign vn_ctn_almost_full = (fifo_cnt >= OCC_W'(PACKET_FIFO_SIZE - 2));
  assign enq                = vn_ctn_packet_valid && !fifo_full;
  assign deq                = issue && last_flit;
  assign occ_next           = fifo_cnt + OCC_W'(enq) - OCC_W'(deq);

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {vn_ctn_packet_dest, vn_ctn_packet_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PTR_W'(PACKET_FIFO_SIZE - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= (rd_ptr == PTR_W'(PACKET_FIFO_SIZE - 1)) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(vn_ctn_packet_valid && fifo_full));
  end

  assign head_entry = mem[rd_ptr];
  assign head_dest  = head_entry[ENTRY_W-1 -: DEST_W];
  assign head_pkt   = head_entry[PACKET_BODY_SIZE-1:0];
  assign padded_pkt = PAD_W'(head_pkt);

  // A flit leaves only when enabled and the router has not switched us off.
  assign issue     = enable && !router_credit && !fifo_empty &&
                     (state_q == IDLE || state_q == SEND);
  assign last_flit = (flit_cnt == CNT_W'(FLIT_NUMB - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      flit_cnt <= '0;
    end else begin
      state_q  <= state_d;
      flit_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = flit_cnt;
    case (state_q)
      IDLE:    if (issue) state_d = SEND;
      SEND:    state_d = SEND;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (last_flit) begin
        cnt_d   = '0;
        state_d = (occ_next != '0) ? SEND : IDLE;
      end else begin
        cnt_d = flit_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    flit_d                    = '0;
    flit_d.header.vc_id       = VCID;
    flit_d.header.destination = FLIT_DEST_W'(head_dest);
    flit_d.payload            = padded_pkt[int'(flit_cnt)*`PAYLOAD_W +: `PAYLOAD_W];
    if (FLIT_NUMB == 1)       flit_d.header.flit_type = HT;
    else if (flit_cnt == '0)  flit_d.header.flit_type = HEAD;
    else if (last_flit)       flit_d.header.flit_type = TAIL;
    else                      flit_d.header.flit_type = BODY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ni_flit_valid <= 1'b0;
      ni_flit_out   <= '0;
    end else begin
      ni_flit_valid <= issue;
      if (issue) ni_flit_out <= flit_d;
    end
  end

`ifdef VN_CTN_FLIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)              vn_ctn_flit_count <= '0;
    else if (ni_flit_valid) vn_ctn_flit_count <= vn_ctn_flit_count + 32'd1;
  end
`else
  assign vn_ctn_flit_count = '0;
`endif
endmodule

// File: tb/tb_virtual_network_core_to_net.sv
// Directed bench for virtual_network_core_to_net: a 200-bit (4-flit) and a 64-bit (single-flit) instance.
module tb_virtual_network_core_to_net;
  import vn_ctn_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [199:0] pkt;
  logic [7:0]  dest;
  logic        pkt_valid, credit;
  logic        af;
  flit_t       flit;
  logic        flit_valid;
  logic [31:0] flit_count;

  logic [63:0] pkt64;
  logic [7:0]  dest64;
  logic        valid64, credit64;
  logic        af64;
  flit_t       flit64;
  logic        flit_valid64;
  logic [31:0] flit_count64;

  int checks   = 0;
  int failures = 0;

  flit_type_t  types4 [4] = '{HEAD, BODY, BODY, TAIL};
  logic [63:0] ht_pl  [3] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};

  virtual_network_core_to_net #(.VCID(VC1), .PACKET_BODY_SIZE(200), .PACKET_FIFO_SIZE(4), .DEST_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vn_ctn_packet_in(pkt), .vn_ctn_packet_dest(dest), .vn_ctn_packet_valid(pkt_valid),
    .vn_ctn_almost_full(af), .ni_flit_out(flit), .ni_flit_valid(flit_valid),
    .router_credit(credit), .vn_ctn_flit_count(flit_count)
  );

  virtual_network_core_to_net #(.VCID(VC1), .PACKET_BODY_SIZE(64), .PACKET_FIFO_SIZE(4), .DEST_W(8)) dut64 (
    .clk(clk), .reset(reset), .enable(enable),
    .vn_ctn_packet_in(pkt64), .vn_ctn_packet_dest(dest64), .vn_ctn_packet_valid(valid64),
    .vn_ctn_almost_full(af64), .ni_flit_out(flit64), .ni_flit_valid(flit_valid64),
    .router_credit(credit64), .vn_ctn_flit_count(flit_count64)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic v, input flit_t f,
                             input flit_type_t t, input logic [63:0] pl, input logic [7:0] d);
    check({tag, "_valid"}, v, 1'b1);
    check({tag, "_type"}, f.header.flit_type, t);
    check({tag, "_payload"}, f.payload, pl);
    check({tag, "_dest"}, f.header.destination, d);
    check({tag, "_vc"}, f.header.vc_id, VC1);
  endtask

  function automatic logic [63:0] slice_val(int p, int k);
    if (k == 3) return 64'(8'h80 + 8'(p));
    return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(k);
  endfunction

  function automatic logic [199:0] make_packet(int p);
    logic [63:0] s3;
    s3 = slice_val(p, 3);
    return {s3[7:0], slice_val(p, 2), slice_val(p, 1), slice_val(p, 0)};
  endfunction

  task automatic send(input logic [199:0] p, input logic [7:0] d);
    pkt = p; dest = d; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; pkt = '0; dest = '0; pkt_valid = 1'b0; credit = 1'b0;
    pkt64 = '0; dest64 = '0; valid64 = 1'b0; credit64 = 1'b0;
    repeat (2) tick();
    check("rst_valid", flit_valid, 1'b0);
    check("rst_out", flit, '0);
    check("rst_af", af, 1'b0);
    check("rst_count", flit_count, 32'd0);
    check("rst_valid64", flit_valid64, 1'b0);
    reset = 1'b0;
    tick();

    // Single packet, hand-written slices
    send({8'hDD, 64'h1357_9BDF_2468_CCCC, 64'hFEDC_BA98_7654_BBBB, 64'h0123_4567_89AB_AAAA}, 8'h05);
    check("s1_no_early", flit_valid, 1'b0);
    tick(); expect_flit("s1_f0", flit_valid, flit, HEAD, 64'h0123_4567_89AB_AAAA, 8'h05);
    tick(); expect_flit("s1_f1", flit_valid, flit, BODY, 64'hFEDC_BA98_7654_BBBB, 8'h05);
    tick(); expect_flit("s1_f2", flit_valid, flit, BODY, 64'h1357_9BDF_2468_CCCC, 8'h05);
    tick(); expect_flit("s1_f3", flit_valid, flit, TAIL, 64'h0000_0000_0000_00DD, 8'h05);
    tick(); check("s1_end", flit_valid, 1'b0);
    check("s1_hold", flit.payload, 64'h0000_0000_0000_00DD);

    // Back-pressure for three cycles after the second flit
    send(make_packet(1), 8'h0A);
    tick(); expect_flit("s2_f0", flit_valid, flit, HEAD, slice_val(1, 0), 8'h0A);
    tick(); expect_flit("s2_f1", flit_valid, flit, BODY, slice_val(1, 1), 8'h0A);
    credit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("s2_gap", flit_valid, 1'b0);
    end
    credit = 1'b0;
    tick(); expect_flit("s2_f2", flit_valid, flit, BODY, slice_val(1, 2), 8'h0A);
    tick(); expect_flit("s2_f3", flit_valid, flit, TAIL, slice_val(1, 3), 8'h0A);
    tick(); check("s2_end", flit_valid, 1'b0);

    // Three packets queued behind a held credit, then drained back to back
    credit = 1'b1;
    for (int p = 2; p < 5; p++) begin
      pkt = make_packet(p); dest = 8'(8'h10 + p); pkt_valid = 1'b1;
      tick();
      check("s3_af_fill", af, (p == 2) ? 1'b0 : 1'b1);
    end
    pkt_valid = 1'b0;
    check("s3_blocked", flit_valid, 1'b0);
    credit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_flit("s3_flit", flit_valid, flit, types4[i % 4], slice_val(2 + i / 4, i % 4), 8'(8'h10 + 2 + i / 4));
    end
    tick();
    check("s3_end", flit_valid, 1'b0);
    check("s3_af_drain", af, 1'b0);

    // Single-flit instance: three back-to-back HT flits
    for (int i = 0; i < 3; i++) begin
      pkt64 = ht_pl[i]; dest64 = 8'(8'h20 + i); valid64 = 1'b1;
      tick();
      if (i == 0) check("s64_no_early", flit_valid64, 1'b0);
      else expect_flit("s64_ht", flit_valid64, flit64, HT, ht_pl[i-1], 8'(8'h20 + i - 1));
    end
    valid64 = 1'b0;
    tick(); expect_flit("s64_ht_last", flit_valid64, flit64, HT, ht_pl[2], 8'h22);
    tick(); check("s64_end", flit_valid64, 1'b0);

    // Reset one cycle after HEAD issues discards the packet
    send(make_packet(5), 8'h33);
    tick(); expect_flit("s4_head", flit_valid, flit, HEAD, slice_val(5, 0), 8'h33);
    reset = 1'b1;
    tick();
    check("s4_rst_valid", flit_valid, 1'b0);
    check("s4_rst_out", flit, '0);
    check("s4_rst_af", af, 1'b0);
    check("s4_rst_count", flit_count, 32'd0);
    check("s4_rst_count64", flit_count64, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("s4_quiet", flit_valid, 1'b0);
    end

    // enable low before and during a packet freezes issue
    enable = 1'b0;
    send(make_packet(6), 8'h44);
    tick(); check("s5_en_off", flit_valid, 1'b0);
    enable = 1'b1;
    tick(); expect_flit("s5_head", flit_valid, flit, HEAD, slice_val(6, 0), 8'h44);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); check("s5_frozen", flit_valid, 1'b0);
    end
    enable = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick(); expect_flit("s5_flit", flit_valid, flit, types4[k], slice_val(6, k), 8'h44);
    end

    // Second 4-flit packet since reset
    send(make_packet(7), 8'h55);
    for (int k = 0; k < 4; k++) begin
      tick(); expect_flit("s6_flit", flit_valid, flit, types4[k], slice_val(7, k), 8'h55);
    end
    tick();
    check("s6_end", flit_valid, 1'b0);
`ifdef VN_CTN_FLIT_COUNT_EN
    check("flit_count", flit_count, 32'd8);
`else
    check("flit_count", flit_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
